// File: rtl/mem_scan_pkg.sv
// Shared constants, state encoding and row-step helper for the 4x4 bit-memory
// read sequencer and the array that sits beside it.
package mem_scan_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    WAIT,
    PRESENT,
    DONE
  } scan_state_t;

  // Row after r, wrapping ROWS-1 -> 0 even when ROWS is not a power of two.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(ROWS - 1)) ? '0 : r + 1'b1;
  endfunction

endpackage

// File: rtl/mem_row_scanner_if.sv
// Scan-control, array-address and word-output signals of the row scanner.
// Handshake: a word moves on a rising clock edge where word_valid and word_ready
// are both high; word_data/word_row stay stable while word_valid waits for ready.
interface mem_row_scanner_if;
  import mem_scan_pkg::*;

  logic               start;
  logic               abort;
  logic [ROW_W-1:0]   row_first;
  logic [ROW_W-1:0]   row_last;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   column;
  logic               bit_in;
  logic [COLS-1:0]    word_data;
  logic [ROW_W-1:0]   word_row;
  logic               word_valid;
  logic               word_ready;
  logic               busy;
  logic               done;
  scan_state_t        dbg_state;

  modport master (
    input  start, abort, row_first, row_last, bit_in, word_ready,
    output row, column, word_data, word_row, word_valid, busy, done, dbg_state
  );

  modport slave (
    output start, abort, row_first, row_last, bit_in, word_ready,
    input  row, column, word_data, word_row, word_valid, busy, done, dbg_state
  );

endinterface

// File: rtl/mem_row_scanner.sv
// Read sequencer for the bit-memory array: walks an inclusive (possibly wrapping)
// row range, packs each row's bits into a word and hands it downstream.
module mem_row_scanner
  import mem_scan_pkg::*;
#(
  parameter int RD_LAT = 0
) (
  input  logic              _clock,
  input  logic              _reset,
  mem_row_scanner_if.master bus
);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] last_q;
  logic [ROW_W-1:0] word_row_q;
  logic [COL_W-1:0] col_q;
  logic [COLS-1:0]  acc_q;
  logic [COLS-1:0]  acc_next;
  logic [COLS-1:0]  word_q;
  logic             launch;
  logic             capture;
  logic             last_col;
  logic             handshake;
  logic             at_last;

  assign launch    = (state == IDLE) && bus.start && !bus.abort;
  assign capture   = !bus.abort && ((RD_LAT == 0) ? (state == SAMPLE) : (state == WAIT));
  assign last_col  = (col_q == COL_W'(COLS - 1));
  assign handshake = (state == PRESENT) && bus.word_ready && !bus.abort;
  assign at_last   = (row_q == last_q);

  always_comb begin
    acc_next        = acc_q;
    acc_next[col_q] = bus.bit_in;
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (launch) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (RD_LAT != 0)   state_next = WAIT;
        else if (last_col) state_next = PRESENT;
      end
      WAIT: begin
        state_next = last_col ? PRESENT : SAMPLE;
      end
      PRESENT: begin
        if (bus.word_ready) state_next = at_last ? DONE : SAMPLE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a handshake in the same cycle.
    if (bus.abort) state_next = IDLE;
  end

  // Bits accumulate in acc_q so the presented word only changes when a full row
  // has been gathered.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      row_q      <= '0;
      last_q     <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      word_q     <= '0;
      word_row_q <= '0;
    end else begin
      if (launch) begin
        row_q  <= bus.row_first;
        last_q <= bus.row_last;
        col_q  <= '0;
      end
      if (capture) begin
        acc_q <= acc_next;
        if (last_col) begin
          word_q     <= acc_next;
          word_row_q <= row_q;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (handshake && !at_last) begin
        row_q <= next_row(row_q);
        col_q <= '0;
      end
    end
  end

  always_comb begin
    bus.word_valid = (state == PRESENT);
    bus.busy       = (state != IDLE);
    bus.done       = (state == DONE);
    bus.dbg_state  = state;
  end

  assign bus.row       = row_q;
  assign bus.column    = col_q;
  assign bus.word_data = word_q;
  assign bus.word_row  = word_row_q;

endmodule

// File: tb/tb_mem_row_scanner.sv
// Bench for mem_row_scanner: one RD_LAT=0 and one RD_LAT=1 instance reading a
// shared 4x4 array model, checked against a row-range reference model.
module tb_mem_row_scanner;
  import mem_scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, word_ready, use1;
  logic [1:0] row_first, row_last;
  logic [3:0] mem [4];
  logic bit1;

  int n_tests, n_fail;

  logic [3:0] exp_q[$];
  logic [1:0] exp_row_q[$];
  logic [3:0] got_q[$];
  logic [1:0] got_row_q[$];
  int done_cnt, lat, hold_err;
  logic timeout, busy_after;

  mem_row_scanner_if if0();
  mem_row_scanner_if if1();

  mem_row_scanner #(.RD_LAT(0)) u_dut0 (._clock(clk), ._reset(rst_n), .bus(if0));
  mem_row_scanner #(.RD_LAT(1)) u_dut1 (._clock(clk), ._reset(rst_n), .bus(if1));

  always #5 clk = ~clk;

  assign if0.start      = start & ~use1;
  assign if1.start      = start & use1;
  assign if0.abort      = abort;
  assign if1.abort      = abort;
  assign if0.row_first  = row_first;
  assign if1.row_first  = row_first;
  assign if0.row_last   = row_last;
  assign if1.row_last   = row_last;
  assign if0.word_ready = word_ready;
  assign if1.word_ready = word_ready;

  // Array model: combinational read for RD_LAT=0, one-cycle registered for RD_LAT=1.
  assign if0.bit_in = mem[if0.row][if0.column];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit1 <= 1'b0;
    else        bit1 <= mem[if1.row][if1.column];
  end
  assign if1.bit_in = bit1;

  logic       o_valid, o_busy, o_done;
  logic [3:0] o_data;
  logic [1:0] o_row;
  assign o_valid = use1 ? if1.word_valid : if0.word_valid;
  assign o_busy  = use1 ? if1.busy       : if0.busy;
  assign o_done  = use1 ? if1.done       : if0.done;
  assign o_data  = use1 ? if1.word_data  : if0.word_data;
  assign o_row   = use1 ? if1.word_row   : if0.word_row;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  // Reference: every row from f stepping by one modulo ROWS up to and including l.
  task automatic build_exp(input int f, input int l);
    int r;
    exp_q.delete();
    exp_row_q.delete();
    r = f;
    for (int k = 0; k < ROWS; k++) begin
      exp_q.push_back(mem[r]);
      exp_row_q.push_back(2'(r));
      if (r == l) break;
      r = (r + 1) % ROWS;
    end
  endtask

  function automatic string fmt_q(input bit want_exp);
    string s;
    s = "";
    if (want_exp) foreach (exp_q[i]) s = {s, $sformatf("%h@%0d ", exp_q[i], exp_row_q[i])};
    else          foreach (got_q[i]) s = {s, $sformatf("%h@%0d ", got_q[i], got_row_q[i])};
    return s;
  endfunction

  function automatic bit words_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i])
      if (got_q[i] !== exp_q[i] || got_row_q[i] !== exp_row_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Driver: launch a scan and record every transferred word until done (+1 cycle).
  task automatic collect(input logic [1:0] f, input logic [1:0] l,
                         input int ready_pct, input int poke_at);
    logic       prev_v, fin;
    logic [3:0] prev_d;
    logic [1:0] prev_r;
    got_q.delete();
    got_row_q.delete();
    done_cnt = 0; lat = -1; hold_err = 0; timeout = 1'b1; busy_after = 1'b1;
    prev_v = 1'b0; prev_d = '0; prev_r = '0; fin = 1'b0;
    row_first = f; row_last = l; start = 1'b1; word_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (fin) begin
        busy_after = o_busy;
        timeout = 1'b0;
        break;
      end
      if (o_done) begin done_cnt++; fin = 1'b1; end
      if (o_valid && lat < 0) lat = n;
      if (o_valid && prev_v && (o_data !== prev_d || o_row !== prev_r)) hold_err++;
      word_ready = ($urandom_range(0, 99) < ready_pct);
      if (o_valid && word_ready) begin
        got_q.push_back(o_data);
        got_row_q.push_back(o_row);
      end
      prev_v = o_valid && !word_ready; prev_d = o_data; prev_r = o_row;
      if (n == poke_at) begin
        start = 1'b1; row_first = ~f; row_last = ~l;
      end else begin
        start = 1'b0; row_first = f; row_last = l;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; word_ready = 1'b0;
    if (timeout) begin
      abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({if0.word_valid, if0.busy, if0.done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags0: got %b, expected 000", {if0.word_valid, if0.busy, if0.done});
    end
    n_tests++;
    if ({if0.row, if0.column, if0.word_data, if0.word_row} !== 10'd0) begin
      n_fail++; $display("FAIL reset_data0: got %h, expected 0", {if0.row, if0.column, if0.word_data, if0.word_row});
    end
    n_tests++;
    if ({if1.word_valid, if1.busy, if1.done, if1.row, if1.column, if1.word_data, if1.word_row} !== 13'd0) begin
      n_fail++; $display("FAIL reset_all1: got %h, expected 0",
        {if1.word_valid, if1.busy, if1.done, if1.row, if1.column, if1.word_data, if1.word_row});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy got %b, expected 0", o_busy);
    end
  endtask

  task automatic test_full_scan();
    use1 = 1'b0;
    mem[0] = 4'hA; mem[1] = 4'h5; mem[2] = 4'hF; mem[3] = 4'h0;
    build_exp(0, 3);
    collect(2'd0, 2'd3, 100, 0);
    n_tests++;
    if (!words_match()) begin
      n_fail++; $display("FAIL full_scan_words: got %s, expected %s", fmt_q(0), fmt_q(1));
    end
    n_tests++;
    if (done_cnt !== 1 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL full_scan_done: done pulses %0d busy %b, expected 1 and 0", done_cnt, busy_after);
    end
    n_tests++;
    if (lat !== COLS + 1) begin
      n_fail++; $display("FAIL full_scan_latency: got %0d, expected %0d", lat, COLS + 1);
    end
  endtask

  task automatic test_wrap();
    use1 = 1'b0;
    build_exp(3, 1);
    collect(2'd3, 2'd1, 100, 0);
    n_tests++;
    if (!words_match() || done_cnt !== 1) begin
      n_fail++; $display("FAIL wrap_words: got %s done %0d, expected %s done 1", fmt_q(0), done_cnt, fmt_q(1));
    end
  endtask

  task automatic test_backpressure();
    logic stable;
    use1 = 1'b0;
    build_exp(0, 1);
    row_first = 2'd0; row_last = 2'd1; start = 1'b1; word_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20 && !o_valid; n++) begin @(posedge clk); #1; end
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== exp_q[0] || o_row !== 2'd0) begin
      n_fail++; $display("FAIL bp_first_word: valid %b data %h row %0d, expected 1 %h 0", o_valid, o_data, o_row, exp_q[0]);
    end
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b1 || o_data !== exp_q[0] || o_row !== 2'd0 || if0.column !== 2'd3) stable = 1'b0;
    end
    n_tests++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got unstable word (now %h@%0d valid %b), expected held %h@0", o_data, o_row, o_valid, exp_q[0]);
    end
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    n_tests++;
    if ({o_valid, o_busy, if0.row, if0.column} !== {1'b0, 1'b1, 2'd1, 2'd0}) begin
      n_fail++; $display("FAIL bp_release: valid/busy/row/col got %b, expected 0_1_01_00", {o_valid, o_busy, if0.row, if0.column});
    end
    repeat (COLS) begin @(posedge clk); #1; end
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== exp_q[1] || o_row !== 2'd1) begin
      n_fail++; $display("FAIL bp_second_word: valid %b data %h row %0d, expected 1 %h 1", o_valid, o_data, o_row, exp_q[1]);
    end
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    n_tests++;
    if (o_done !== 1'b1) begin
      n_fail++; $display("FAIL bp_done: got %b, expected 1", o_done);
    end
    @(posedge clk); #1;
    n_tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: busy %b done %b, expected 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_abort();
    int seen, dones;
    use1 = 1'b0;
    for (int i = 0; i < ROWS; i++) mem[i] = 4'($urandom_range(0, 15));
    build_exp(0, 3);
    seen = 0; dones = 0;
    row_first = 2'd0; row_last = 2'd3; start = 1'b1; word_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (o_valid) begin
        seen++;
        word_ready = 1'b1;
        if (seen == 2) begin
          abort = 1'b1;
          @(posedge clk); #1;
          break;
        end
      end else begin
        word_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; word_ready = 1'b0;
    n_tests++;
    if (seen !== 2 || {o_valid, o_busy, o_done} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle: words seen %0d valid/busy/done %b, expected 2 and 000", seen, {o_valid, o_busy, o_done});
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (o_done || o_valid) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL abort_quiet: done/valid seen %0d cycles, expected 0", dones);
    end
    collect(2'd0, 2'd3, 100, 0);
    n_tests++;
    if (!words_match() || done_cnt !== 1) begin
      n_fail++; $display("FAIL abort_rescan: got %s done %0d, expected %s done 1", fmt_q(0), done_cnt, fmt_q(1));
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL start_abort_idle: busy got %b, expected 0", o_busy);
    end
  endtask

  task automatic test_async_reset();
    use1 = 1'b0;
    mem[0] = 4'hA; mem[1] = 4'h5; mem[2] = 4'hF; mem[3] = 4'h0;
    row_first = 2'd1; row_last = 2'd3; start = 1'b1; word_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if0.word_valid, if0.busy, if0.done, if0.row, if0.column, if0.word_data, if0.word_row} !== 13'd0) begin
      n_fail++; $display("FAIL async_reset: got %h, expected 0",
        {if0.word_valid, if0.busy, if0.done, if0.row, if0.column, if0.word_data, if0.word_row});
    end
    #2 rst_n = 1'b1;
    word_ready = 1'b0;
    @(posedge clk); #1;
    build_exp(0, 3);
    collect(2'd0, 2'd3, 100, 0);
    n_tests++;
    if (!words_match() || done_cnt !== 1 || busy_after !== 1'b0 || lat !== COLS + 1) begin
      n_fail++; $display("FAIL async_rescan: got %s done %0d busy %b lat %0d, expected %s done 1 busy 0 lat %0d",
        fmt_q(0), done_cnt, busy_after, lat, fmt_q(1), COLS + 1);
    end
  endtask

  task automatic test_rd_lat1();
    use1 = 1'b1;
    mem[2] = 4'h6;
    build_exp(2, 2);
    collect(2'd2, 2'd2, 100, 0);
    n_tests++;
    if (!words_match()) begin
      n_fail++; $display("FAIL lat1_word: got %s, expected %s", fmt_q(0), fmt_q(1));
    end
    n_tests++;
    if (lat !== 2 * COLS + 1) begin
      n_fail++; $display("FAIL lat1_latency: got %0d, expected %0d", lat, 2 * COLS + 1);
    end
    n_tests++;
    if (done_cnt !== 1 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL lat1_done: done %0d busy %b, expected 1 0", done_cnt, busy_after);
    end
    use1 = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] f, l;
    int poke, exp_lat;
    for (int it = 0; it < 10; it++) begin
      use1 = 1'($urandom_range(0, 1));
      for (int i = 0; i < ROWS; i++) mem[i] = 4'($urandom_range(0, 15));
      f = 2'($urandom_range(0, 3));
      l = 2'($urandom_range(0, 3));
      poke = (it % 2 == 1) ? int'($urandom_range(2, 12)) : 0;
      exp_lat = use1 ? 2 * COLS + 1 : COLS + 1;
      build_exp(f, l);
      collect(f, l, 60, poke);
      n_tests++;
      if (!words_match() || hold_err !== 0) begin
        n_fail++; $display("FAIL random_words[%0d] lat%0d %0d->%0d poke %0d: got %s hold_err %0d, expected %s",
          it, use1, f, l, poke, fmt_q(0), hold_err, fmt_q(1));
      end
      n_tests++;
      if (done_cnt !== 1 || busy_after !== 1'b0 || lat !== exp_lat) begin
        n_fail++; $display("FAIL random_done[%0d]: done %0d busy %b lat %0d, expected 1 0 %0d",
          it, done_cnt, busy_after, lat, exp_lat);
      end
    end
    use1 = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    start = 1'b0; abort = 1'b0; word_ready = 1'b0; use1 = 1'b0;
    row_first = '0; row_last = '0; rst_n = 1'b0;
    for (int i = 0; i < ROWS; i++) mem[i] = '0;
    test_reset();
    test_full_scan();
    test_wrap();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_rd_lat1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
